// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and widths for the PCIe TX arbiter slice.
package pcie_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      CFG  = 2'd2
   } arb_state_e;

   localparam int TUSER_W    = 4;
   localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/pcie_tx_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module pcie_tx_rr_pick
   import pcie_tx_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   int cand;

   // Walk the offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = (int'(last_grant) + k) % NUM_REQ;
         if (req[cand]) begin
            valid = 1'b1;
            idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Shares the core's AXI4-Stream TX port between NUM_REQ TLP sources, switching
// only at TLP boundaries and yielding to configuration TLPs between packets.
module pcie_tx_arbiter
   import pcie_tx_arb_pkg::*;
#(
   parameter  int NUM_REQ    = 2,
   parameter  int DATA_W     = 64,
   parameter  int KEEP_W     = DATA_W / 8,
   parameter  int MIN_BUF_AV = 2,
   localparam int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                         user_clk,
   input  logic                         user_reset_n,
   input  logic                         user_lnk_up,
   input  logic [NUM_REQ*DATA_W-1:0]    req_tdata,
   input  logic [NUM_REQ*KEEP_W-1:0]    req_tkeep,
   input  logic [NUM_REQ*TUSER_W-1:0]   req_tuser,
   input  logic [NUM_REQ-1:0]           req_tlast,
   input  logic [NUM_REQ-1:0]           req_tvalid,
   output logic [NUM_REQ-1:0]           req_tready,
   output logic [DATA_W-1:0]            s_axis_tx_tdata,
   output logic [KEEP_W-1:0]            s_axis_tx_tkeep,
   output logic [TUSER_W-1:0]           s_axis_tx_tuser,
   output logic                         s_axis_tx_tlast,
   output logic                         s_axis_tx_tvalid,
   input  logic                         s_axis_tx_tready,
   input  logic [5:0]                   tx_buf_av,
   input  logic                         tx_cfg_req,
   output logic                         tx_cfg_gnt,
   input  logic                         tx_err_drop,
   output logic [IDX_W-1:0]             grant_id,
   output logic                         busy,
   output logic [DROP_CNT_W-1:0]        drop_count
);

   localparam logic [5:0] MIN_AV = 6'(MIN_BUF_AV);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  last_grant_q, last_grant_d, grant_d;
   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;
   logic              tlp_done;

   pcie_tx_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req        (req_tvalid),
      .last_grant (last_grant_q),
      .valid      (pick_valid),
      .idx        (pick_idx)
   );

   assign tlp_done = s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_id;
      last_grant_d = last_grant_q;
      unique case (state_q)
         IDLE: begin
            if (tx_cfg_req) begin
               state_d = CFG;
            end else if (pick_valid && (tx_buf_av >= MIN_AV)) begin
               state_d = PASS;
               grant_d = pick_idx;
            end
         end
         PASS: begin
            if (tlp_done) begin
               last_grant_d = grant_id;
               state_d      = IDLE;
            end
         end
         CFG: begin
            if (!tx_cfg_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Link loss abandons any TLP in flight; the core flushes its own TX side.
      if (!user_lnk_up) begin
         state_d      = IDLE;
         last_grant_d = last_grant_q;
      end
   end

   always_ff @(posedge user_clk) begin
      if (!user_reset_n) begin
         state_q      <= IDLE;
         grant_id     <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q      <= state_d;
         grant_id     <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_ff @(posedge user_clk) begin
      if (!user_reset_n) begin
         drop_count <= '0;
      end else if (tx_err_drop && (drop_count != '1)) begin
         drop_count <= drop_count + 1'b1;
      end
   end

   // Pure mux in PASS; ready depends only on the core's ready, never on req_tvalid.
   always_comb begin
      s_axis_tx_tdata  = '0;
      s_axis_tx_tkeep  = '0;
      s_axis_tx_tuser  = '0;
      s_axis_tx_tlast  = 1'b0;
      s_axis_tx_tvalid = 1'b0;
      req_tready       = '0;
      if (state_q == PASS) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDX_W'(i)) begin
               s_axis_tx_tdata  = req_tdata[i*DATA_W +: DATA_W];
               s_axis_tx_tkeep  = req_tkeep[i*KEEP_W +: KEEP_W];
               s_axis_tx_tuser  = req_tuser[i*TUSER_W +: TUSER_W];
               s_axis_tx_tlast  = req_tlast[i];
               s_axis_tx_tvalid = req_tvalid[i];
               req_tready[i]    = s_axis_tx_tready;
            end
         end
      end
   end

   assign busy       = (state_q == PASS);
   assign tx_cfg_gnt = (state_q == CFG);

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed + randomized bench for pcie_tx_arbiter with a TLP-level reference model.
module tb_pcie_tx_arbiter;

   localparam int NR = 2;
   localparam int DW = 64;
   localparam int KW = 8;
   localparam int M_IDLE = 0;
   localparam int M_TLP  = 1;
   localparam int M_CFG  = 2;

   logic              user_clk = 1'b0;
   logic              user_reset_n;
   logic              user_lnk_up;
   logic [NR*DW-1:0]  req_tdata;
   logic [NR*KW-1:0]  req_tkeep;
   logic [NR*4-1:0]   req_tuser;
   logic [NR-1:0]     req_tlast;
   logic [NR-1:0]     req_tvalid;
   logic [NR-1:0]     req_tready;
   logic [DW-1:0]     s_axis_tx_tdata;
   logic [KW-1:0]     s_axis_tx_tkeep;
   logic [3:0]        s_axis_tx_tuser;
   logic              s_axis_tx_tlast;
   logic              s_axis_tx_tvalid;
   logic              s_axis_tx_tready;
   logic [5:0]        tx_buf_av;
   logic              tx_cfg_req;
   logic              tx_cfg_gnt;
   logic              tx_err_drop;
   logic [0:0]        grant_id;
   logic              busy;
   logic [15:0]       drop_count;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic [3:0]  user;
      logic        last;
   } beat_t;

   beat_t q0[$];
   beat_t q1[$];
   int    dseq[$];
   int    mode, cur, mlast, mdl_drop;
   int    vectors = 0;
   int    miscompares = 0;
   logic [NR-1:0] src_en;
   logic  busy_prev;

   always #5 user_clk = ~user_clk;

   pcie_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .KEEP_W(KW), .MIN_BUF_AV(2)) dut (
      .user_clk         (user_clk),
      .user_reset_n     (user_reset_n),
      .user_lnk_up      (user_lnk_up),
      .req_tdata        (req_tdata),
      .req_tkeep        (req_tkeep),
      .req_tuser        (req_tuser),
      .req_tlast        (req_tlast),
      .req_tvalid       (req_tvalid),
      .req_tready       (req_tready),
      .s_axis_tx_tdata  (s_axis_tx_tdata),
      .s_axis_tx_tkeep  (s_axis_tx_tkeep),
      .s_axis_tx_tuser  (s_axis_tx_tuser),
      .s_axis_tx_tlast  (s_axis_tx_tlast),
      .s_axis_tx_tvalid (s_axis_tx_tvalid),
      .s_axis_tx_tready (s_axis_tx_tready),
      .tx_buf_av        (tx_buf_av),
      .tx_cfg_req       (tx_cfg_req),
      .tx_cfg_gnt       (tx_cfg_gnt),
      .tx_err_drop      (tx_err_drop),
      .grant_id         (grant_id),
      .busy             (busy),
      .drop_count       (drop_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic beat_t front(input int i);
      beat_t z;
      z = '0;
      if (i == 0 && q0.size() > 0) return q0[0];
      if (i == 1 && q1.size() > 0) return q1[0];
      return z;
   endfunction

   task automatic pop(input int i);
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endtask

   task automatic clear(input int i);
      if (i == 0) q0.delete();
      else        q1.delete();
   endtask

   task automatic push_tlp(input int r, input int n);
      beat_t b;
      for (int j = 0; j < n; j++) begin
         b.data = {$urandom, $urandom};
         b.keep = (j == n - 1) ? 8'h0F : 8'hFF;
         b.user = 4'($urandom);
         b.last = (j == n - 1);
         if (r == 0) q0.push_back(b);
         else        q1.push_back(b);
      end
   endtask

   // Round-robin at TLP granularity: first pending source after the last served one.
   function automatic int rr_next(input int last_g);
      int c;
      for (int k = 1; k <= NR; k++) begin
         c = (last_g + k) % NR;
         if (req_tvalid[c]) return c;
      end
      return -1;
   endfunction

   task automatic tick();
      beat_t b;
      logic [NR-1:0] exp_rdy;
      logic hs, hs_last;
      int nxt;
      for (int i = 0; i < NR; i++) begin
         b = front(i);
         req_tdata[i*DW +: DW] = b.data;
         req_tkeep[i*KW +: KW] = b.keep;
         req_tuser[i*4 +: 4]   = b.user;
         req_tlast[i]          = b.last;
         req_tvalid[i]         = src_en[i] && (qsize(i) > 0);
      end
      #1;
      b = front(cur);
      exp_rdy = '0;
      chk("busy", 64'(busy), 64'(mode == M_TLP));
      chk("cfg_gnt", 64'(tx_cfg_gnt), 64'(mode == M_CFG));
      chk("drop_count", 64'(drop_count), 64'(mdl_drop));
      chk("grant_id", 64'(grant_id), 64'(cur));
      if (mode == M_TLP) begin
         exp_rdy[cur] = s_axis_tx_tready;
         chk("tvalid", 64'(s_axis_tx_tvalid), 64'(req_tvalid[cur]));
         if (req_tvalid[cur]) begin
            chk("tdata", s_axis_tx_tdata, b.data);
            chk("tkeep", 64'(s_axis_tx_tkeep), 64'(b.keep));
            chk("tuser", 64'(s_axis_tx_tuser), 64'(b.user));
            chk("tlast", 64'(s_axis_tx_tlast), 64'(b.last));
         end
      end else begin
         chk("tvalid_idle", 64'(s_axis_tx_tvalid), 64'd0);
         chk("tdata_idle", s_axis_tx_tdata, 64'd0);
      end
      chk("req_tready", 64'(req_tready), 64'(exp_rdy));
      if (busy && !busy_prev) dseq.push_back(int'(grant_id));
      busy_prev = busy;
      hs      = (mode == M_TLP) && req_tvalid[cur] && s_axis_tx_tready;
      hs_last = hs && b.last;
      @(posedge user_clk);
      if (!user_reset_n) begin
         mode = M_IDLE; mlast = NR - 1; cur = 0; mdl_drop = 0;
      end else begin
         if (tx_err_drop && mdl_drop < 65535) mdl_drop++;
         if (!user_lnk_up) begin
            mode = M_IDLE;
         end else if (mode == M_IDLE) begin
            nxt = rr_next(mlast);
            if (tx_cfg_req) mode = M_CFG;
            else if (nxt >= 0 && tx_buf_av >= 6'd2) begin
               cur = nxt; mode = M_TLP;
            end
         end else if (mode == M_TLP) begin
            if (hs_last) begin mlast = cur; mode = M_IDLE; end
         end else begin
            if (!tx_cfg_req) mode = M_IDLE;
         end
      end
      if (hs) pop(cur);
      @(negedge user_clk);
   endtask

   task automatic drain(input int max, input bit rnd);
      int n;
      n = 0;
      while ((qsize(0) + qsize(1)) > 0 && n < max) begin
         if (rnd) s_axis_tx_tready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      s_axis_tx_tready = 1'b1;
      chk("drain_timeout", 64'(qsize(0) + qsize(1)), 64'd0);
      tick();
   endtask

   initial begin
      int r0, g, n;
      user_reset_n = 1'b0; user_lnk_up = 1'b1; s_axis_tx_tready = 1'b1;
      tx_buf_av = 6'd8; tx_cfg_req = 1'b0; tx_err_drop = 1'b0; src_en = 2'b11;
      req_tdata = '0; req_tkeep = '0; req_tuser = '0; req_tlast = '0; req_tvalid = '0;
      repeat (2) @(posedge user_clk);
      @(negedge user_clk);
      mode = M_IDLE; mlast = NR - 1; cur = 0; mdl_drop = 0; busy_prev = 1'b0;
      tick(); tick();
      user_reset_n = 1'b1;

      // fairness: both sources continuously valid with 3-beat TLPs
      for (int t = 0; t < 2; t++) begin push_tlp(0, 3); push_tlp(1, 3); end
      drain(60, 1'b0);
      chk("fair_ntlp", 64'(dseq.size()), 64'd4);
      for (int j = 0; j < 4; j++)
         if (j < dseq.size()) chk("fair_seq", 64'(dseq[j]), 64'(j % 2));

      // backpressure: core ready 1,0,0,1 mid-TLP, then random TLPs with random ready
      push_tlp(0, 4);
      tick();
      s_axis_tx_tready = 1'b1; tick();
      s_axis_tx_tready = 1'b0; tick(); tick();
      s_axis_tx_tready = 1'b1;
      drain(40, 1'b0);
      for (int t = 0; t < 8; t++) push_tlp($urandom_range(0, 1), $urandom_range(1, 5));
      drain(400, 1'b1);

      // configuration request raised during beat 2 of a 4-beat TLP
      dseq.delete();
      r0 = (mlast + 1) % NR;
      push_tlp(r0, 4);
      tick();
      n = 0;
      while (qsize(r0) > 3 && n < 10) begin tick(); n++; end
      tx_cfg_req = 1'b1;
      push_tlp(0, 2); push_tlp(1, 2);
      repeat (8) tick();
      chk("cfg_gnt_held", 64'(tx_cfg_gnt), 64'd1);
      tx_cfg_req = 1'b0;
      drain(60, 1'b0);
      chk("cfg_ntlp", 64'(dseq.size()), 64'd3);
      if (dseq.size() >= 2) begin
         chk("cfg_first", 64'(dseq[0]), 64'(r0));
         chk("cfg_after", 64'(dseq[1]), 64'(1 - r0));
      end

      // buffer gate
      src_en = 2'b01; tx_buf_av = 6'd1;
      push_tlp(0, 3);
      repeat (5) tick();
      chk("gate_no_grant", 64'(busy), 64'd0);
      tx_buf_av = 6'd2;
      tick();
      #1 chk("gate_first_beat", 64'(s_axis_tx_tvalid), 64'd1);
      drain(30, 1'b0);
      src_en = 2'b11; tx_buf_av = 6'd8;

      // link drop mid-TLP, then three drop pulses
      push_tlp(0, 5);
      tick();
      n = 0;
      while (qsize(0) > 3 && n < 10) begin tick(); n++; end
      user_lnk_up = 1'b0; s_axis_tx_tready = 1'b0;
      tick();
      q0.delete();
      s_axis_tx_tready = 1'b1;
      #1 chk("lnk_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
      chk("lnk_idle", 64'(busy), 64'd0);
      repeat (3) begin tx_err_drop = 1'b1; tick(); tx_err_drop = 1'b0; tick(); end
      #1 chk("drop_count_3", 64'(drop_count), 64'd3);
      user_lnk_up = 1'b1;

      // saturation
      tx_err_drop = 1'b1;
      repeat (70000) tick();
      tx_err_drop = 1'b0;
      tick();
      #1 chk("drop_sat", 64'(drop_count), 64'hFFFF);

      // reset during PASS
      push_tlp(0, 4); push_tlp(1, 4);
      tick();
      n = 0;
      while ((qsize(0) + qsize(1)) > 6 && n < 10) begin tick(); n++; end
      g = cur;
      user_reset_n = 1'b0; s_axis_tx_tready = 1'b0;
      tick();
      #1 chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      chk("rst_grant", 64'(grant_id), 64'd0);
      clear(g); push_tlp(g, 3);
      user_reset_n = 1'b1; s_axis_tx_tready = 1'b1;
      dseq.delete();
      drain(60, 1'b0);
      chk("rst_ntlp", 64'(dseq.size()), 64'd2);
      if (dseq.size() > 0) chk("rst_first_grant", 64'(dseq[0]), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
